pipe_hazard_ctl: RTL
====================

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port clrn, input, 1 bit: synchronous, active-high reset; 1 at a rising clk edge clears all state.
REQ-003 The block SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-004 The block SHALL have ports id_rs and id_rt, input, 5 bits each: ID source register numbers.
REQ-005 The block SHALL have ports id_rs1_isreg and id_rs2_isreg, input, 1 bit each: the ID instruction reads rs or rt respectively.
REQ-006 The block SHALL have port id_isstore, input, 1 bit: the ID instruction is a store; rt is read as store data.
REQ-007 The block SHALL have ports id_wreg and id_m2reg, input, 1 bit each: the ID instruction writes a register, and that write comes from memory (load).
REQ-008 The block SHALL have port id_rn, input, 5 bits: ID destination register number.
REQ-009 The block SHALL have port id_branch, input, 1 bit: the ID instruction redirects the PC (pcsource != 0).
REQ-010 The block SHALL have ports fwda and fwdb, output, 2 bits each: operand source selects for a and b.
- 00 = register file
- 01 = EXE ALU result
- 10 = MEM ALU result
- 11 = MEM load data
REQ-011 The block SHALL have port wpcir, output, 1 bit: PC and IF/ID register write enable.
REQ-012 The block SHALL have port bubble, output, 1 bit: convert the ID/EXE entry into a NOP.
REQ-013 The block SHALL have port flush_if, output, 1 bit: invalidate the instruction being fetched.
REQ-014 The block SHALL have port stall_cnt, output, 16 bits: count of load-use stall cycles.

Function
REQ-015 The block SHALL keep two stage records, E and M, each holding {valid, wreg, m2reg, rn[4:0]}.
REQ-016 Each rising edge, M SHALL take E.
REQ-017 Each rising edge, E SHALL take {id_valid & ~bubble, id_wreg, id_m2reg, id_rn}.
REQ-018 Operand use SHALL be defined as: usea = id_rs1_isreg; useb = id_rs2_isreg | id_isstore.
REQ-019 A stage SHALL hit operand x when all hold: valid & wreg, rn != 0, and rn equals that operand's register number.
REQ-020 fwda and fwdb SHALL be combinational, with this priority:
- E hit with E.m2reg = 0 -> 01
- else M hit -> 10 if M.m2reg = 0, 11 if M.m2reg = 1
- else 00
REQ-021 A select SHALL be 00 whenever its operand is unused or id_valid = 0.
REQ-022 A load-use hazard SHALL exist when: id_valid, and E is valid, E.wreg, E.m2reg, E.rn != 0, and E.rn matches a used operand.
REQ-023 On a load-use hazard, the block SHALL drive wpcir = 0 and bubble = 1 in the same cycle, with latency 0.
REQ-024 A load-use hazard SHALL last exactly one cycle; the next cycle the ID instruction SHALL get 11 from M.
REQ-025 Register 0 SHALL never cause forwarding or a stall.
REQ-026 A write by the WB stage SHALL NOT be forwarded; the register file writes on the falling edge, so 00 is correct.
REQ-027 flush_if SHALL be id_valid & id_branch & ~stall.
REQ-028 A branch in a stall cycle SHALL NOT flush; its flush SHALL occur in the cycle it resolves.
REQ-029 When id_valid = 0, the block SHALL drive wpcir = 1, bubble = 0 and flush_if = 0.
REQ-030 stall_cnt SHALL increment by 1 in each stall cycle and saturate at 16'hFFFF without wrapping.
REQ-031 If a stall and clrn occur in the same cycle, reset SHALL win, and stall_cnt SHALL be 0 after the edge.

Reset
REQ-032 When clrn = 1 at an edge, the block SHALL clear E.valid, M.valid and stall_cnt to 0.
REQ-033 Reset SHALL clear E.rn, M.rn, E.wreg, E.m2reg, M.wreg and M.m2reg to 0.
REQ-034 After reset with id_valid = 0, the outputs SHALL be: fwda = fwdb = 00, wpcir = 1, bubble = 0, flush_if = 0, stall_cnt = 0.
REQ-035 A reset in the middle of a stall SHALL discard the pending hazard; the next cycle SHALL have no stall.

Verification
REQ-036 The bench SHALL cover ALU-ALU forwarding: add r3 then sub r5,r3,r4 back to back -> fwda = 01, fwdb = 00, wpcir = 1.
REQ-037 The bench SHALL cover load-use: lw r3 then add r6,r3,r3 -> cycle 1: wpcir = 0, bubble = 1, stall_cnt = 1; cycle 2: fwda = fwdb = 11, wpcir = 1.
REQ-038 The bench SHALL cover E over M priority: add r3, add r3, then or r7,r3,r0 -> fwda = 01, not 10.
REQ-039 The bench SHALL cover register 0 and store data:
- writer to r0, then reader of r0 -> fwda = 00, no stall
- add r9, then sw with rt = r9 and id_rs2_isreg = 0 -> fwdb = 01
REQ-040 The bench SHALL cover branch flush: branch with id_branch = 1 and no hazard -> flush_if = 1 for one cycle.
REQ-041 The bench SHALL cover a branch after a load-use hazard -> flush_if = 0 in the stall cycle and flush_if = 1 in the next cycle.
REQ-042 The bench SHALL cover counter saturation and reset: preload stall_cnt = 16'hFFFF and apply a stall -> stays FFFF; assert clrn mid-stall -> stall_cnt = 0 and wpcir = 1 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctl_if.sv
// Hazard-control bundle between the ID stage and the hazard unit.
// The ID stage (master) presents the decoded instruction.
// The hazard unit (slave) returns the forwarding selects and the stall/flush controls.
interface pipe_hazard_ctl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs1_isreg;
  logic        id_rs2_isreg;
  logic        id_isstore;
  logic        id_wreg;
  logic        id_m2reg;
  logic [4:0]  id_rn;
  logic        id_branch;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic        wpcir;
  logic        bubble;
  logic        flush_if;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs1_isreg, id_rs2_isreg, id_isstore,
           id_wreg, id_m2reg, id_rn, id_branch,
    input  fwda, fwdb, wpcir, bubble, flush_if, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs1_isreg, id_rs2_isreg, id_isstore,
           id_wreg, id_m2reg, id_rn, id_branch,
    output fwda, fwdb, wpcir, bubble, flush_if, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Hazard control for a 5-stage pipeline.
// Tracks the destination records of the EXE (E) and MEM (M) stages.
// From them it produces the operand forwarding selects and the load-use stall.
// It also produces the fetch flush for taken branches and a saturating count of stall cycles.
// Forwarding, stall and flush are combinational because the pipeline needs them in the same cycle.
module pipe_hazard_ctl (
  input  logic               clk,
  input  logic               clrn,
  pipe_hazard_ctl_if.slave   bus
);

  logic        e_valid_r;
  logic        e_wreg_r;
  logic        e_m2reg_r;
  logic [4:0]  e_rn_r;
  logic        m_valid_r;
  logic        m_wreg_r;
  logic        m_m2reg_r;
  logic [4:0]  m_rn_r;
  logic [15:0] stall_cnt_r;

  logic        usea_s;
  logic        useb_s;
  logic        e_hit_a_s;
  logic        e_hit_b_s;
  logic        m_hit_a_s;
  logic        m_hit_b_s;
  logic        stall_s;
  logic [1:0]  fwda_s;
  logic [1:0]  fwdb_s;

  // A stage supplies an operand only when it really writes a non-zero register.
  // Register 0 is hard-wired, so writes to it are never forwarded.
  function automatic logic stage_hit(input logic valid, input logic wreg,
                                     input logic [4:0] rn, input logic [4:0] src);
    return valid & wreg & (rn != 5'd0) & (rn == src);
  endfunction

  // Youngest producer wins. A load still in EXE has no data yet, so it falls through to MEM.
  function automatic logic [1:0] fwd_sel(input logic use_op, input logic e_hit,
                                         input logic e_load, input logic m_hit,
                                         input logic m_load);
    logic [1:0] sel;
    sel = 2'b00;
    if (!use_op) begin
      sel = 2'b00;
    end else if (e_hit && !e_load) begin
      sel = 2'b01;
    end else if (m_hit) begin
      sel = m_load ? 2'b11 : 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand usage, stage hits, forwarding selects and load-use detection.
  always_comb begin
    usea_s    = bus.id_valid & bus.id_rs1_isreg;
    useb_s    = bus.id_valid & (bus.id_rs2_isreg | bus.id_isstore);
    e_hit_a_s = stage_hit(e_valid_r, e_wreg_r, e_rn_r, bus.id_rs);
    e_hit_b_s = stage_hit(e_valid_r, e_wreg_r, e_rn_r, bus.id_rt);
    m_hit_a_s = stage_hit(m_valid_r, m_wreg_r, m_rn_r, bus.id_rs);
    m_hit_b_s = stage_hit(m_valid_r, m_wreg_r, m_rn_r, bus.id_rt);
    fwda_s    = fwd_sel(usea_s, e_hit_a_s, e_m2reg_r, m_hit_a_s, m_m2reg_r);
    fwdb_s    = fwd_sel(useb_s, e_hit_b_s, e_m2reg_r, m_hit_b_s, m_m2reg_r);
    stall_s   = e_m2reg_r & ((usea_s & e_hit_a_s) | (useb_s & e_hit_b_s));
  end

  assign bus.fwda      = fwda_s;
  assign bus.fwdb      = fwdb_s;
  assign bus.wpcir     = ~stall_s;
  assign bus.bubble    = stall_s;
  assign bus.flush_if  = bus.id_valid & bus.id_branch & ~stall_s;
  assign bus.stall_cnt = stall_cnt_r;

  // Advance the E and M stage records; a stalled ID instruction enters E as a bubble.
  always_ff @(posedge clk) begin
    if (clrn) begin
      e_valid_r <= 1'b0;
      e_wreg_r  <= 1'b0;
      e_m2reg_r <= 1'b0;
      e_rn_r    <= 5'd0;
      m_valid_r <= 1'b0;
      m_wreg_r  <= 1'b0;
      m_m2reg_r <= 1'b0;
      m_rn_r    <= 5'd0;
    end else begin
      m_valid_r <= e_valid_r;
      m_wreg_r  <= e_wreg_r;
      m_m2reg_r <= e_m2reg_r;
      m_rn_r    <= e_rn_r;
      e_valid_r <= bus.id_valid & ~stall_s;
      e_wreg_r  <= bus.id_wreg;
      e_m2reg_r <= bus.id_m2reg;
      e_rn_r    <= bus.id_rn;
    end
  end

  // Count load-use stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clrn) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
